// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter/sequencer feeding two clients into one shared AES core.
// Handles the level-sensitive start/done handshake plus timeout-and-drain recovery.
module aes_core_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int DRAIN   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    input  logic         key_valid,
    output logic         core_start,
    output logic [127:0] core_data_in,
    input  logic         core_done,
    input  logic [127:0] core_data_out,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         resp_id,
    output logic         resp_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] LP_DR_LAST = 8'(DRAIN - 1);

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_cnt;
    logic         r_last;
    logic         r_id;
    logic         r_err;
    logic [127:0] r_din;
    logic [127:0] r_dout;

    logic w_grant_en;
    logic w_pick0;
    logic w_pick1;
    logic w_accept;
    logic w_timeout;
    logic w_drain_end;
    logic w_start;

    // On a tie the requester that was not served last wins
    assign w_pick1     = req1_valid & (~req0_valid | ~r_last);
    assign w_pick0     = req0_valid & ~w_pick1;
    assign w_grant_en  = (r_state == S_IDLE) & key_valid & reset;
    assign req0_ready  = w_grant_en & w_pick0;
    assign req1_ready  = w_grant_en & w_pick1;
    assign w_accept    = req0_ready | req1_ready;
    assign w_timeout   = (r_cnt == LP_TO_LAST);
    assign w_drain_end = (r_cnt == LP_DR_LAST);

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_start = ~core_done;
                if (core_done || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) w_next = r_err ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (w_drain_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= 8'd0;
            r_last <= 1'b1;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
            r_din  <= 128'd0;
            r_dout <= 128'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_din  <= w_pick1 ? req1_data : req0_data;
                        r_id   <= w_pick1;
                        r_last <= w_pick1;
                        r_cnt  <= 8'd0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        r_dout <= core_data_out;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_dout <= 128'd0;
                        r_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready && r_err) r_cnt <= 8'd0;
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    assign core_start   = w_start & reset;
    assign core_data_in = r_din;
    assign resp_valid   = (r_state == S_RESP);
    assign resp_data    = r_dout;
    assign resp_id      = r_id;
    assign resp_err     = r_err;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a latency-programmable AES core stub.
// Stub returns the FIPS-197 vector for the known plaintext, otherwise data ^ MASK.
module tb_aes_core_arbiter;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MASK = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid;
    logic [127:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [127:0] req1_data;
    logic         req1_ready;
    logic         key_valid;
    logic         core_start;
    logic [127:0] core_data_in;
    logic         core_done;
    logic [127:0] core_data_out;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic         resp_id;
    logic         resp_err;
    logic         busy;

    logic stub_done;
    logic done_inj;
    int   stub_lat;
    int   s_cnt;
    int   vectors = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    aes_core_arbiter #(.TIMEOUT(64), .DRAIN(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .key_valid(key_valid), .core_start(core_start),
        .core_data_in(core_data_in), .core_done(core_done),
        .core_data_out(core_data_out), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .resp_err(resp_err), .busy(busy)
    );

    function automatic logic [127:0] gold(input logic [127:0] x);
        return (x == PT) ? CT : (x ^ MASK);
    endfunction

    // stub_lat = 0 means the core hangs and never signals done
    assign core_data_out = gold(core_data_in);
    assign core_done     = stub_done | done_inj;

    always @(posedge clk) begin
        if (!reset) begin
            s_cnt     <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (core_start) begin
                if (stub_lat != 0 && s_cnt == stub_lat - 1) begin
                    stub_done <= 1'b1;
                    s_cnt     <= 0;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end else begin
                s_cnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_resp_valid"}, 128'(resp_valid), 128'(1'b1));
    endtask

    // Called at a negedge in IDLE with requests already driven
    task automatic run_txn(input string tag, input logic exp_id,
                           input logic [127:0] exp_data, input bit drop);
        #1;
        chk({tag, "_grant"}, 128'({req1_ready, req0_ready}),
            128'(exp_id ? 2'b10 : 2'b01));
        @(negedge clk);
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk({tag, "_start"}, 128'(core_start), 128'(1'b1));
        wait_resp(tag);
        chk({tag, "_id"}, 128'(resp_id), 128'(exp_id));
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_err"}, 128'(resp_err), 128'(1'b0));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_idle"}, 128'(busy), 128'(1'b0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 128'({resp_valid, resp_id, resp_err, busy,
            core_start, req0_ready, req1_ready}), 128'(7'd0));
        chk({tag, "_rdata"}, resp_data, 128'd0);
        chk({tag, "_cdin"}, core_data_in, 128'd0);
    endtask

    initial begin
        logic seen;
        reset      = 1'b0;
        key_valid  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 128'h0a0a0a0a_00000000_11111111_22222222;
        req1_data  = 128'h1b1b1b1b_33333333_44444444_55555555;
        resp_ready = 1'b0;
        done_inj   = 1'b0;
        stub_lat   = 3;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");

        key_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("keygate", 128'({req1_ready, req0_ready, busy, core_start}),
                128'(4'd0));
        end

        key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn("tie", i[0], i[0] ? gold(req1_data) : gold(req0_data),
                    i == 3);
        end

        done_inj = 1'b1;
        @(negedge clk);
        done_inj = 1'b0;
        #1;
        chk("done_idle", 128'({busy, resp_valid, core_start}), 128'(3'd0));

        req0_data  = PT;
        req0_valid = 1'b1;
        #1;
        chk("t1_grant", 128'({req1_ready, req0_ready}), 128'(2'b01));
        @(negedge clk);
        req0_valid = 1'b0;
        req0_data  = 128'hdeadbeef;
        chk("t1_start", 128'(core_start), 128'(1'b1));
        chk("t1_cdin", core_data_in, PT);
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t1_start_fall", 128'({core_done, core_start}), 128'(2'b10));
        @(negedge clk);
        chk("t1_valid", 128'(resp_valid), 128'(1'b1));
        chk("t1_data", resp_data, CT);
        chk("t1_id_err", 128'({resp_id, resp_err}), 128'(2'b00));
        resp_ready = 1'b1;
        key_valid  = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("t1_idle", 128'({busy, resp_valid}), 128'(2'b00));

        stub_lat   = 2;
        req0_data  = 128'h3c3c3c3c_01234567_89abcdef_fedcba98;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp("bp");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 128'h77777777_88888888_99999999_aaaaaaaa;
        repeat (20) begin
            #1;
            chk("bp_hold", 128'({resp_valid, resp_id, resp_err, req0_ready,
                req1_ready, core_start}), 128'(6'b100000));
            chk("bp_data", resp_data,
                gold(128'h3c3c3c3c_01234567_89abcdef_fedcba98));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        run_txn("bp_next", 1'b1, gold(req1_data), 1'b1);

        stub_lat   = 0;
        req0_data  = 128'hc0c0c0c0_12121212_34343434_56565656;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (63) @(negedge clk);
        chk("to_pre", 128'({resp_valid, core_start}), 128'(2'b01));
        @(negedge clk);
        chk("to_valid", 128'({resp_valid, resp_err, resp_id}), 128'(3'b110));
        chk("to_data", resp_data, 128'd0);
        req1_data  = 128'hd0d0d0d0_abababab_cdcdcdcd_efefefef;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        stub_lat   = 3;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain", 128'({core_start, req1_ready, busy}), 128'(3'b001));
            @(negedge clk);
        end
        run_txn("to_next", 1'b1, gold(req1_data), 1'b1);

        stub_lat   = 63;
        req0_data  = 128'he0e0e0e0_13579bdf_2468ace0_0f1e2d3c;
        req0_valid = 1'b1;
        run_txn("edge_done", 1'b0, gold(req0_data), 1'b1);

        stub_lat   = 3;
        req0_data  = 128'hf0f0f0f0_00000001_00000002_00000003;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("midrst");
        reset = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_noresp", 128'(seen), 128'(1'b0));
        req1_data  = 128'h1f1f1f1f_00000004_00000005_00000006;
        req1_valid = 1'b1;
        run_txn("post_rst", 1'b1, gold(req1_data), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Two-requester round-robin arbiter and sequencer for the shared AES encryption core. Accepts 128-bit plaintext blocks from two independent clients over valid/ready handshakes and serialises them onto the core's level-sensitive `start`/`done` interface. Returns each ciphertext with a requester ID and recovers from a hung core through a timeout-and-drain sequence. Sits between the client logic and the AES core; the key-expansion block remains the core's key source.

## Interface

**Parameters**
- `TIMEOUT`, default 64: maximum cycles in ISSUE waiting for `core_done`. Range 2–255.
- `DRAIN`, default 16: cycles `core_start` is held low after a timeout before the next grant. Range 1–255.

**Ports** (clock and reset first)
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a block.
- `req0_data` in 128: requester 0 plaintext.
- `req0_ready` out 1: requester 0 block accepted this cycle when valid is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `key_valid` in 1: key expansion complete. No grant is made while this is low.
- `core_start` out 1: to core `start`.
- `core_data_in` out 128: to core `data_in`.
- `core_done` in 1: from core `done`.
- `core_data_out` in 128: from core `data_out`.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 128: ciphertext. Zero on error.
- `resp_id` out 1: requester that owns the result.
- `resp_err` out 1: result produced by a timeout.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

**States**
- **IDLE**
  - Grant when `key_valid`=1 and at least one `reqN_valid`=1.
  - If both requesters are valid, grant the one not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` is combinational: it is high only for the selected requester, only in IDLE, and only while `key_valid`=1.
  - On `valid`&`ready`: capture data into the `core_data_in` register, record the ID, update the pointer, clear the cycle counter, and go to ISSUE.
- **ISSUE**
  - `core_start` = (state==ISSUE) & ~`core_done`, combinational. Because it drops in the same cycle `done` is seen, the core never re-samples `start` high when it returns to IDLE.
  - The counter increments each cycle.
  - On `core_done`=1: register `core_data_out` into `resp_data`, set `resp_err`=0, and go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT`-1: set `resp_data`=0 and `resp_err`=1, and go to RESP.
- **RESP**
  - `resp_valid`=1. `resp_data`, `resp_id` and `resp_err` are held stable until `resp_ready`=1.
  - On accept: go to IDLE if `resp_err`=0; otherwise go to DRAIN.
- **DRAIN**
  - `core_start`=0. Count `DRAIN` cycles so the aborted core reaches its DONE state with `start` low, discards its output and returns to idle.
  - Then go to IDLE.

**Boundary rules**
- `core_done` outside ISSUE is ignored. No state change and no output change.
- `core_done` in the same cycle the counter hits `TIMEOUT`-1: done wins and `resp_err`=0.
- `key_valid` falling during ISSUE: no effect on the operation in flight. It only gates new grants.
- Only one block is in flight. No request is accepted from ISSUE until the RESP accept.
- `req*_data` is sampled only on the handshake cycle. Later changes are ignored.

**Reset** (`reset`=0 at a clock edge)
- State goes to IDLE and the pointer goes to 1.
- `resp_valid`, `resp_data`, `resp_id`, `resp_err`, `busy` and `core_data_in` go to 0.
- `core_start`=0 and `req*_ready`=0 while reset is asserted.
- Reset mid-ISSUE abandons the operation with no response. The system must reset the core in the same window.

## Timing

- Handshake at edge E0 → ISSUE from E0+1, with `core_start` high in that cycle.
- `core_done` high in cycle D → `resp_valid` high from cycle D+1.
- `resp_ready` high in cycle R → IDLE in R+1, and a new grant is possible in R+1.
- Back-to-back throughput: core latency + 3 cycles per block.
- Timeout path: `resp_valid` rises `TIMEOUT` cycles after ISSUE entry. After the accept, IDLE is reached `DRAIN` cycles later.

## Test plan

1. **Single block.** Key 000102…0f expanded. `req0` sends 00112233445566778899aabbccddeeff.
   - Required: `resp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `resp_id`=0, `resp_err`=0.
   - Required: `core_start` falls in the `core_done` cycle.
2. **Tie alternation.** Both requesters are valid continuously with distinct blocks.
   - Required: grants go 0,1,0,1; each `resp_id` matches its requester; the ciphertexts match the golden model.
3. **Response back-pressure.** Hold `resp_ready`=0 for 20 cycles.
   - Required: `resp_*` is stable, both `req*_ready` stay 0, and no `core_start` is issued.
   - Release `resp_ready`: the next grant occurs one cycle later.
4. **Timeout.** A core stub never asserts done, with `TIMEOUT`=64 and `DRAIN`=16.
   - Required: `resp_err`=1 and `resp_data`=0 64 cycles after ISSUE entry.
   - Required: after the accept, `core_start` stays 0 for 16 cycles and then the next grant happens.
5. **Key gating and simultaneous events.**
   - With `key_valid`=0 and requests pending: `req*_ready` stays 0 and `busy`=0.
   - A stub asserts done on exactly the `TIMEOUT`-1 cycle: `resp_err`=0 and the data is passed through.
6. **Reset mid-operation.** Drive `reset`=0 for one cycle during ISSUE.
   - Required: all outputs are zero the next cycle and no response is emitted.
   - The following request completes correctly.
